// File: rtl/banked_ram_if.sv
// Bus bundle for banked_ram: clear control plus one read and one write port.
// Parameters must match those of the banked_ram instance it connects to.
interface banked_ram_if #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 4,
    parameter int B_WIDTH = 2
);
    logic               clr_i;
    logic               busy_o;
    logic               ren_i;
    logic [B_WIDTH-1:0] rbank_i;
    logic [A_WIDTH-1:0] raddr_i;
    logic [D_WIDTH-1:0] rdata_o;
    logic               rvalid_o;
    logic               wen_i;
    logic [B_WIDTH-1:0] wbank_i;
    logic [A_WIDTH-1:0] waddr_i;
    logic [D_WIDTH-1:0] wdata_i;

    modport master (
        output clr_i, ren_i, rbank_i, raddr_i, wen_i, wbank_i, waddr_i, wdata_i,
        input  busy_o, rdata_o, rvalid_o
    );

    modport slave (
        input  clr_i, ren_i, rbank_i, raddr_i, wen_i, wbank_i, waddr_i, wdata_i,
        output busy_o, rdata_o, rvalid_o
    );
endinterface

// File: rtl/banked_ram.sv
// Multi-bank simple dual-port RAM with a hardware clear sweep, 1- or 2-cycle
// read latency with a valid strobe, and a selectable read/write collision policy.
module banked_ram #(
    parameter int                 D_WIDTH     = 8,
    parameter int                 A_WIDTH     = 4,
    parameter int                 B_WIDTH     = 2,
    parameter int                 RD_LAT      = 1,
    parameter int                 WR_FIRST    = 0,
    parameter logic [D_WIDTH-1:0] INIT_VAL    = '0,
    parameter int                 INIT_ON_RST = 1
) (
    input  logic       clk,
    input  logic       rst,
    banked_ram_if.slave bus
);
    localparam int                 IDX_W    = A_WIDTH + B_WIDTH;
    localparam int                 N_WORDS  = 2 ** IDX_W;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_WORDS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               mem_we;
    logic [IDX_W-1:0]   mem_widx;
    logic [D_WIDTH-1:0] mem_wdata;
    logic [D_WIDTH-1:0] mem [N_WORDS];

    logic               busy;
    logic               rd_acc;
    logic               wr_acc;
    logic [IDX_W-1:0]   ridx;
    logic [IDX_W-1:0]   widx;
    logic [D_WIDTH-1:0] rd_word;

    assign busy   = (state_q == CLEAR);
    assign rd_acc = bus.ren_i && !busy;
    assign wr_acc = bus.wen_i && !busy;
    assign ridx   = {bus.rbank_i, bus.raddr_i};
    assign widx   = {bus.wbank_i, bus.waddr_i};
    assign bus.busy_o = busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= (INIT_ON_RST != 0) ? CLEAR : IDLE;
            cnt_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = wr_acc;
        mem_widx  = widx;
        mem_wdata = bus.wdata_i;
        case (state_q)
            IDLE: begin
                if (bus.clr_i) state_d = CLEAR;
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_widx  = cnt_q;
                mem_wdata = INIT_VAL;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the array has no reset; only the clear sweep or writes give it defined contents.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_widx] <= mem_wdata;
    end

    // Write-first forwards wdata on a same-index collision; read-first sees the old word.
    assign rd_word = ((WR_FIRST != 0) && wr_acc && (widx == ridx)) ? bus.wdata_i : mem[ridx];

    logic               rvalid1_q;
    logic [D_WIDTH-1:0] rdata1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid1_q <= 1'b0;
            rdata1_q  <= '0;
        end else begin
            rvalid1_q <= rd_acc;
            if (rd_acc) rdata1_q <= rd_word;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic               rvalid2_q;
        logic [D_WIDTH-1:0] rdata2_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rvalid2_q <= 1'b0;
                rdata2_q  <= '0;
            end else begin
                rvalid2_q <= rvalid1_q;
                if (rvalid1_q) rdata2_q <= rdata1_q;
            end
        end

        assign bus.rvalid_o = rvalid2_q;
        assign bus.rdata_o  = rdata2_q;
    end else begin : g_lat1
        assign bus.rvalid_o = rvalid1_q;
        assign bus.rdata_o  = rdata1_q;
    end
endmodule

// File: tb/tb_banked_ram.sv
// Randomised bench for banked_ram: two instances (read-first/latency 1 and
// write-first/latency 2) driven in lockstep and compared against a word-array model.
module tb_banked_ram;
    localparam int N = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    banked_ram_if #(.D_WIDTH(8), .A_WIDTH(4), .B_WIDTH(2)) bus_a ();
    banked_ram_if #(.D_WIDTH(8), .A_WIDTH(4), .B_WIDTH(2)) bus_b ();

    banked_ram #(.D_WIDTH(8), .A_WIDTH(4), .B_WIDTH(2), .RD_LAT(1), .WR_FIRST(0),
                 .INIT_VAL(8'h00), .INIT_ON_RST(1))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    banked_ram #(.D_WIDTH(8), .A_WIDTH(4), .B_WIDTH(2), .RD_LAT(2), .WR_FIRST(1),
                 .INIT_VAL(8'h5A), .INIT_ON_RST(1))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Reference model: word arrays, remaining sweep cycles, and reads due at a cycle number.
    typedef struct {
        int         inst;
        int         due;
        logic [7:0] data;
    } rd_t;

    rd_t        pend[$];
    logic [7:0] mem_m   [2][N];
    int         busy_m  [2];
    logic [7:0] last_m  [2];
    int         lat_m   [2] = '{1, 2};
    bit         wrf_m   [2] = '{1'b0, 1'b1};
    logic [7:0] init_m  [2] = '{8'h00, 8'h5A};
    int         ec;
    int         checks;
    int         errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input bit at_reset);
        for (int i = 0; i < 2; i++) begin
            logic       got_v, got_b, exp_v;
            logic [7:0] got_d;
            got_v = (i == 0) ? bus_a.rvalid_o : bus_b.rvalid_o;
            got_d = (i == 0) ? bus_a.rdata_o  : bus_b.rdata_o;
            got_b = (i == 0) ? bus_a.busy_o   : bus_b.busy_o;
            exp_v = 1'b0;
            if (!at_reset) begin
                for (int k = 0; k < pend.size(); k++) begin
                    if (pend[k].inst == i) begin
                        if (pend[k].due == ec) begin
                            exp_v     = 1'b1;
                            last_m[i] = pend[k].data;
                            pend.delete(k);
                        end
                        break;
                    end
                end
            end
            check($sformatf("rvalid[%0d]", i), 32'(got_v), 32'(exp_v));
            check($sformatf("rdata[%0d]", i),  32'(got_d), 32'(last_m[i]));
            check($sformatf("busy[%0d]", i),   32'(got_b), 32'(busy_m[i] > 0));
        end
    endtask

    // One clock cycle: drive both instances, advance the model at the edge, compare.
    task automatic step(input bit clr, input bit ren, input logic [5:0] ridx,
                        input bit wen, input logic [5:0] widx, input logic [7:0] wd);
        bus_a.clr_i = clr; bus_a.ren_i = ren; bus_a.rbank_i = ridx[5:4]; bus_a.raddr_i = ridx[3:0];
        bus_a.wen_i = wen; bus_a.wbank_i = widx[5:4]; bus_a.waddr_i = widx[3:0]; bus_a.wdata_i = wd;
        bus_b.clr_i = clr; bus_b.ren_i = ren; bus_b.rbank_i = ridx[5:4]; bus_b.raddr_i = ridx[3:0];
        bus_b.wen_i = wen; bus_b.wbank_i = widx[5:4]; bus_b.waddr_i = widx[3:0]; bus_b.wdata_i = wd;
        @(posedge clk);
        ec++;
        for (int i = 0; i < 2; i++) begin
            if (busy_m[i] == 0) begin
                if (ren) begin
                    rd_t e;
                    e.inst = i;
                    e.due  = ec + lat_m[i] - 1;
                    e.data = (wen && widx == ridx && wrf_m[i]) ? wd : mem_m[i][ridx];
                    pend.push_back(e);
                end
                if (wen) mem_m[i][widx] = wd;
                if (clr) busy_m[i] = N;
            end else begin
                mem_m[i][N - busy_m[i]] = init_m[i];
                busy_m[i]--;
            end
        end
        #1;
        check_outputs(1'b0);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 8'h00);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        pend.delete();
        for (int i = 0; i < 2; i++) begin
            last_m[i] = 8'h00;
            busy_m[i] = N;
        end
        #1;
        check_outputs(1'b1);
        repeat (cycles) @(posedge clk);
        #1;
        check_outputs(1'b1);
        rst = 1'b0;
    endtask

    task automatic read_all();
        for (int k = 0; k < N; k++) step(1'b0, 1'b1, 6'(k), 1'b0, 6'd0, 8'h00);
        idle(2);
    endtask

    task automatic fill(input logic [7:0] v);
        for (int k = 0; k < N; k++) step(1'b0, 1'b0, 6'd0, 1'b1, 6'(k), v);
    endtask

    task automatic random_ops(input int n, input bit allow_clr);
        for (int c = 0; c < n; c++) begin
            logic [5:0] r, w;
            r = 6'($urandom_range(0, N - 1));
            case ($urandom_range(0, 3))
                0:       w = r;
                1:       w = r ^ {2'($urandom_range(1, 3)), 4'b0000};
                default: w = 6'($urandom_range(0, N - 1));
            endcase
            step(allow_clr && ($urandom_range(0, 15) == 0), 1'($urandom), r,
                 1'($urandom), w, 8'($urandom));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ec     = 0;
        bus_a.clr_i = 1'b0; bus_a.ren_i = 1'b0; bus_a.rbank_i = '0; bus_a.raddr_i = '0;
        bus_a.wen_i = 1'b0; bus_a.wbank_i = '0; bus_a.waddr_i = '0; bus_a.wdata_i = '0;
        bus_b.clr_i = 1'b0; bus_b.ren_i = 1'b0; bus_b.rbank_i = '0; bus_b.raddr_i = '0;
        bus_b.wen_i = 1'b0; bus_b.wbank_i = '0; bus_b.waddr_i = '0; bus_b.wdata_i = '0;
        #2;

        // Power-up sweep with ignored traffic, then every word holds INIT_VAL.
        do_reset(3);
        random_ops(N, 1'b0);
        idle(2);
        read_all();

        // Same address in two banks, untouched third bank.
        step(1'b0, 1'b0, 6'd0, 1'b1, {2'd2, 4'd7}, 8'hA5);
        step(1'b0, 1'b0, 6'd0, 1'b1, {2'd1, 4'd7}, 8'h3C);
        step(1'b0, 1'b1, {2'd2, 4'd7}, 1'b0, 6'd0, 8'h00);
        step(1'b0, 1'b1, {2'd1, 4'd7}, 1'b0, 6'd0, 8'h00);
        step(1'b0, 1'b1, {2'd0, 4'd7}, 1'b0, 6'd0, 8'h00);
        idle(2);

        // Collision at bank 3 addr 5, then re-read.
        step(1'b0, 1'b0, 6'd0, 1'b1, {2'd3, 4'd5}, 8'h11);
        step(1'b0, 1'b1, {2'd3, 4'd5}, 1'b1, {2'd3, 4'd5}, 8'h22);
        step(1'b0, 1'b1, {2'd3, 4'd5}, 1'b0, 6'd0, 8'h00);
        idle(2);

        // Back-to-back reads of a preloaded run.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 6'd0, 1'b1, 6'(k), 8'(8'h10 + k));
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 6'(k), 1'b0, 6'd0, 8'h00);
        idle(3);

        // Mixed random traffic with frequent collisions.
        random_ops(400, 1'b0);
        idle(2);

        // Clear after fill; read issued with clr completes; second clr mid-sweep ignored.
        fill(8'hFF);
        step(1'b0, 1'b1, 6'd9, 1'b0, 6'd0, 8'h00);
        step(1'b1, 1'b1, 6'd10, 1'b0, 6'd0, 8'h00);
        random_ops(20, 1'b0);
        step(1'b1, 1'b1, 6'd3, 1'b1, 6'd3, 8'h77);
        random_ops(N - 21, 1'b0);
        idle(2);
        read_all();

        // Reset aborts a sweep at count 30; sweep reruns in full after release.
        fill(8'hFF);
        step(1'b0, 1'b1, 6'd40, 1'b0, 6'd0, 8'h00);
        step(1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 8'h00);
        idle(30);
        do_reset(2);
        random_ops(N, 1'b1);
        idle(2);
        read_all();

        random_ops(300, 1'b1);
        idle(N + 4);
        read_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
